// File: rtl/mean_window_writer.sv
// Recursive 3x3 mean stage behind the line buffer, emitting the filtered frame as a
// ready/valid stream. Define MEAN_BORDER_ZERO_EN to output 0 for border centres instead of raw R5.

module mean_window_writer #(
    parameter int WIDTH      = 256,
    parameter int HEIGHT     = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] R1,
    input  logic [7:0] R2,
    input  logic [7:0] R3,
    input  logic [7:0] R4,
    input  logic [7:0] R5,
    input  logic [7:0] R6,
    input  logic [7:0] R7,
    input  logic [7:0] R8,
    input  logic [7:0] R9,
    output logic [7:0] feed,
    output logic [7:0] out_pixel,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_eol,
    output logic       out_eof,
    output logic       busy,
    output logic       err
);

    localparam int TOTAL = WIDTH * HEIGHT;
    localparam int T_W   = $clog2(TOTAL + WIDTH + 3);
    localparam int COL_W = $clog2(WIDTH);
    localparam int ROW_W = $clog2(HEIGHT);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [T_W-1:0]   T_LAST_IN = T_W'(TOTAL - 1);
    localparam logic [T_W-1:0]   T_LAST    = T_W'(TOTAL + WIDTH + 1);
    localparam logic [T_W-1:0]   T_CTR_GO  = T_W'(WIDTH);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(HEIGHT - 1);
    localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_FLUSH  = 2'd2
    } state_t;

    // Rounded mean of nine 8-bit taps; (sum+4)/9 never exceeds 255.
    function automatic logic [7:0] mean9(input logic [11:0] sum);
        return 8'(({1'b0, sum} + 13'd4) / 13'd9);
    endfunction

    state_t           r_state;
    state_t           w_state_nx;
    logic             w_start;
    logic             w_drop;
    logic [T_W-1:0]   r_t;
    logic             r_c_on;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic             w_final;
    logic             w_interior;
    logic [11:0]      w_sum;
    logic [7:0]       w_mean;
    logic [7:0]       w_out_pix;
    logic             r_s1_valid;
    logic [7:0]       r_s1_pix;
    logic             r_s1_eol;
    logic             r_s1_eof;
    logic [9:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [PTR_W:0]   r_cnt;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_ovf;
    logic             r_busy;
    logic             r_err;

    // Next-state logic: frame start, input-gap abort, end of input and end of flush.
    always_comb begin
        w_state_nx = r_state;
        w_start    = 1'b0;
        w_drop     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_nx = S_ACTIVE;
                    w_start    = 1'b1;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_ACTIVE: begin
                if (r_t == T_LAST_IN) begin
                    w_state_nx = S_FLUSH;
                end else if (!in_valid) begin
                    w_state_nx = S_IDLE;
                    w_drop     = 1'b1;
                end else begin
                    w_state_nx = S_ACTIVE;
                end
            end
            S_FLUSH: begin
                if (r_t == T_LAST) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_state_nx = S_FLUSH;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // State register and busy flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_busy  <= (w_state_nx != S_IDLE);
        end
    end

    // Cycle counter t: 0 on the first cycle the first pixel sits in R9.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_t <= '0;
        end else if (w_start) begin
            r_t <= '0;
        end else if (r_state != S_IDLE) begin
            r_t <= r_t + 1'b1;
        end
    end

    // Centre row/column tracking; the centre reaches index 0 once t equals WIDTH+1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_c_on <= 1'b0;
            r_col  <= '0;
            r_row  <= '0;
        end else if (w_start || w_drop) begin
            r_c_on <= 1'b0;
            r_col  <= '0;
            r_row  <= '0;
        end else if (r_c_on) begin
            if (w_final) begin
                r_c_on <= 1'b0;
            end else if (r_col == COL_LAST) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end else if ((r_state != S_IDLE) && (r_t == T_CTR_GO)) begin
            r_c_on <= 1'b1;
            r_col  <= '0;
            r_row  <= '0;
        end
    end

    assign w_final    = r_c_on && (r_row == ROW_LAST) && (r_col == COL_LAST);
    assign w_interior = r_c_on && (r_row != '0) && (r_row != ROW_LAST)
                               && (r_col != '0) && (r_col != COL_LAST);
    assign w_sum = {4'd0, R1} + {4'd0, R2} + {4'd0, R3} + {4'd0, R4} + {4'd0, R5}
                 + {4'd0, R6} + {4'd0, R7} + {4'd0, R8} + {4'd0, R9};
    assign w_mean = mean9(w_sum);

    // Feedback into the buffer and the value emitted for the current centre.
    always_comb begin
        feed      = R5;
        w_out_pix = R5;
        if (w_interior) begin
            feed      = w_mean;
            w_out_pix = w_mean;
        end else begin
            feed = R5;
`ifdef MEAN_BORDER_ZERO_EN
            w_out_pix = 8'd0;
`else
            w_out_pix = R5;
`endif
        end
    end

    // Output stage 1: pixel with its row/frame markers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            r_s1_pix   <= 8'd0;
            r_s1_eol   <= 1'b0;
            r_s1_eof   <= 1'b0;
        end else begin
            r_s1_valid <= r_c_on;
            r_s1_pix   <= w_out_pix;
            r_s1_eol   <= (r_col == COL_LAST);
            r_s1_eof   <= w_final;
        end
    end

    // A pop frees a slot in the same cycle, so push+pop while full is not an overflow.
    assign w_full = (r_cnt == FIFO_FULL);
    assign w_pop  = out_valid && out_ready;
    assign w_push = r_s1_valid && (!w_full || w_pop);
    assign w_ovf  = r_s1_valid && w_full && !w_pop;

    // Show-ahead FIFO storage and pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 10'd0;
            end
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= {r_s1_eof, r_s1_eol, r_s1_pix};
                r_wr        <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Sticky error, cleared only when a new frame starts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= (w_start ? 1'b0 : r_err) | w_ovf | w_drop;
        end
    end

    assign out_valid = (r_cnt != '0);
    assign out_pixel = r_mem[r_rd][7:0];
    assign out_eol   = r_mem[r_rd][8];
    assign out_eof   = r_mem[r_rd][9];
    assign busy      = r_busy;
    assign err       = r_err;

endmodule

// File: tb/tb_mean_window_writer.sv
// Directed bench for mean_window_writer on an 8x4 frame with a 4-entry output FIFO.
// MEAN_BORDER_ZERO_EN selects the border-zero expectations.

module tb_mean_window_writer;

    localparam int W = 8;
    localparam int H = 4;
    localparam int D = 4;
    localparam int NPIX = W * H;
    localparam int NV = 8;
`ifdef MEAN_BORDER_ZERO_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] taps [9];
    logic [7:0] feed;
    logic [7:0] out_pixel;
    logic       out_valid;
    logic       out_eol;
    logic       out_eof;
    logic       busy;
    logic       err;

    mean_window_writer #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .R1(taps[0]), .R2(taps[1]), .R3(taps[2]), .R4(taps[3]), .R5(taps[4]),
        .R6(taps[5]), .R7(taps[6]), .R8(taps[7]), .R9(taps[8]),
        .feed(feed), .out_pixel(out_pixel), .out_valid(out_valid), .out_ready(out_ready),
        .out_eol(out_eol), .out_eof(out_eof), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    int         vn [NV];
    int         vfeed [NV];
    logic [7:0] vt [NV][9];

    int n_out;
    int first_out;
    int last_out;
    int idle_outs;
    int exp_pix [NPIX];
    bit busy_at [64];
    bit err_at [64];

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Directed windows: cycle n puts centre index n-10 on R5.
    task automatic init_vectors();
        vn[0] = 10; vfeed[0] = 77;  vt[0] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd77, 8'd0, 8'd0, 8'd0, 8'd0};
        vn[1] = 17; vfeed[1] = 200; vt[1] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd200, 8'd0, 8'd0, 8'd0, 8'd0};
        vn[2] = 19; vfeed[2] = 28;  vt[2] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0};
        vn[3] = 20; vfeed[3] = 255; vt[3] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
        vn[4] = 21; vfeed[4] = 1;   vt[4] = '{8'd13, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        vn[5] = 22; vfeed[5] = 2;   vt[5] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd14};
        vn[6] = 23; vfeed[6] = 7;   vt[6] = '{8'd9, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd50};
        vn[7] = 41; vfeed[7] = 9;   vt[7] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0};
    endtask

    function automatic bit is_border(input int k);
        return (k / W == 0) || (k / W == H - 1) || (k % W == 0) || (k % W == W - 1);
    endfunction

    // mode 0: all taps 100; mode 1: 100 plus directed windows; mode 2: all taps n+1.
    task automatic set_taps(input int mode, input int n, output int efeed);
        int v;
        v = (mode == 2) ? (n + 1) : 100;
        for (int i = 0; i < 9; i++) taps[i] = 8'(v);
        efeed = v;
        if (mode == 1) begin
            for (int j = 0; j < NV; j++) begin
                if (vn[j] == n) begin
                    taps  = vt[j];
                    efeed = vfeed[j];
                end
            end
        end
    endtask

    task automatic run_frame(input int mode, input int ncyc, input int nvalid, input logic rdy);
        int ef;
        n_out = 0; first_out = -1; last_out = -1;
        for (int k = 0; k < NPIX; k++) begin
            exp_pix[k] = (mode == 2) ? (k + 11) : 100;
            if (ZERO_EN && is_border(k)) exp_pix[k] = 0;
        end
        if (mode == 1) begin
            for (int j = 0; j < NV; j++)
                exp_pix[vn[j] - 10] = (ZERO_EN && is_border(vn[j] - 10)) ? 0 : vfeed[j];
        end
        for (int n = 0; n < ncyc; n++) begin
            in_valid  = (n < nvalid);
            out_ready = rdy;
            set_taps(mode, n, ef);
            @(negedge clk);
            check_eq($sformatf("feed@%0d", n), int'(feed), ef);
            busy_at[n] = busy;
            err_at[n]  = err;
            if (out_valid && out_ready) begin
                if (n_out < NPIX) begin
                    check_eq($sformatf("pix[%0d]", n_out), int'(out_pixel), exp_pix[n_out]);
                    check_eq($sformatf("eol[%0d]", n_out), int'(out_eol), int'(n_out % W == W - 1));
                    check_eq($sformatf("eof[%0d]", n_out), int'(out_eof), int'(n_out == NPIX - 1));
                    check_eq($sformatf("time[%0d]", n_out), n, n_out + W + 4);
                end
                if (first_out < 0) first_out = n;
                last_out = n;
                n_out++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int ncyc, input logic rdy);
        for (int n = 0; n < ncyc; n++) begin
            in_valid  = 1'b0;
            out_ready = rdy;
            @(negedge clk);
            if (out_valid && out_ready) idle_outs++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        init_vectors();
        for (int i = 0; i < 9; i++) taps[i] = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", int'(out_valid), 0);
        check_eq("rst_out_pixel", int'(out_pixel), 0);
        check_eq("rst_out_eol", int'(out_eol), 0);
        check_eq("rst_out_eof", int'(out_eof), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_err", int'(err), 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Flat frame, sink always ready.
        run_frame(0, 46, NPIX, 1'b1);
        check_eq("f1_count", n_out, NPIX);
        check_eq("f1_first", first_out, W + 4);
        check_eq("f1_last", last_out, NPIX + W + 3);
        check_eq("f1_busy0", int'(busy_at[0]), 0);
        check_eq("f1_busy1", int'(busy_at[1]), 1);
        check_eq("f1_busy42", int'(busy_at[42]), 1);
        check_eq("f1_busy43", int'(busy_at[43]), 0);
        check_eq("f1_err", int'(err), 0);

        // Directed windows: impulse, saturation, rounding, borders.
        run_frame(1, 46, NPIX, 1'b1);
        check_eq("f2_count", n_out, NPIX);
        check_eq("f2_err", int'(err), 0);

        // Sink stalled for the whole frame: overflow, first four pixels retained.
        run_frame(2, 46, NPIX, 1'b0);
        check_eq("f3_err", int'(err), 1);
        check_eq("f3_busy", int'(busy), 0);
        out_ready = 1'b1;
        for (int i = 0; i < D; i++) begin
            @(negedge clk);
            check_eq($sformatf("f3_valid[%0d]", i), int'(out_valid), 1);
            check_eq($sformatf("f3_pix[%0d]", i), int'(out_pixel), exp_pix[i]);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check_eq("f3_empty", int'(out_valid), 0);
        @(posedge clk); #1;

        // in_valid gap at pixel 10.
        run_frame(0, 12, 10, 1'b1);
        check_eq("f4_err_before", int'(err_at[0]), 1);
        check_eq("f4_err_cleared", int'(err_at[1]), 0);
        check_eq("f4_err_n10", int'(err_at[10]), 0);
        check_eq("f4_err_n11", int'(err_at[11]), 1);
        check_eq("f4_busy_n10", int'(busy_at[10]), 1);
        check_eq("f4_busy_n11", int'(busy_at[11]), 0);
        idle(10, 1'b1);

        // Restart, then reset in the middle of FLUSH.
        run_frame(0, 37, NPIX, 1'b1);
        check_eq("f5_first", first_out, W + 4);
        check_eq("f5_count", n_out, 37 - (W + 4));
        check_eq("f5_err_cleared", int'(err_at[1]), 0);
        check_eq("f5_busy_flush", int'(busy), 1);
        rst = 1'b0;
        #1;
        check_eq("mrst_out_valid", int'(out_valid), 0);
        check_eq("mrst_out_pixel", int'(out_pixel), 0);
        check_eq("mrst_out_eol", int'(out_eol), 0);
        check_eq("mrst_out_eof", int'(out_eof), 0);
        check_eq("mrst_busy", int'(busy), 0);
        check_eq("mrst_err", int'(err), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        idle_outs = 0;
        idle(20, 1'b1);
        check_eq("mrst_no_push", idle_outs, 0);
        check_eq("mrst_busy_after", int'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mean_window_writer.md
# mean_window_writer

Consumer end of the 3x3 line-buffer window: accepts the nine window taps each clock, computes the rounded 3x3 mean for interior centre pixels, and drives the `feed` value back into the buffer's left-of-centre tap so that filtering is recursive. It also writes the filtered frame out as a ready/valid pixel stream with row and frame markers. It sits directly behind the line buffer and in front of the frame sink.

## Interface
- `WIDTH`, 256: pixels per row; the line buffer is built with `COUNT = WIDTH-3`.
- `HEIGHT`, 256: rows per frame.
- `FIFO_DEPTH`, 4: output FIFO entries, power of two, minimum 2.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  high while a frame pixel is presented to the buffer's `Pixel` input.
- `R1`..`R9`  in  8 each  window taps; `R5` is the centre, `R4` is the left neighbour, `R9` is the newest pixel.
- `feed`  out  8  combinational feedback to the buffer's `feed` input.
- `out_pixel`  out  8  filtered pixel.
- `out_valid`  out  1  `out_pixel` valid.
- `out_ready`  in  1  sink accepts the pixel when high together with `out_valid`.
- `out_eol`  out  1  qualifies the last pixel of a row.
- `out_eof`  out  1  qualifies the last pixel of a frame.
- `busy`  out  1  high in ACTIVE or FLUSH.
- `err`  out  1  sticky error: a FIFO overflow or a gap in `in_valid` mid-frame.

## Operation
- FSM states: IDLE, ACTIVE, FLUSH.
  - IDLE -> ACTIVE on `in_valid`=1. `err` is cleared and the counters are zeroed on this transition.
  - ACTIVE counts `WIDTH*HEIGHT` input cycles, then moves to FLUSH.
  - FLUSH counts `WIDTH+2` cycles, then returns to IDLE.
  - If `in_valid` drops in ACTIVE before the count completes, set `err` and return to IDLE. FIFO contents are retained.
  - `in_valid` high in FLUSH is ignored; the next frame starts only from IDLE.
- Centre tracking: the cycle counter `t` starts at 0 on the first cycle the first pixel sits in `R9`. The centre index is `t-(WIDTH+1)`. The block decomposes this index into a row `r` and column `c` for indices 0..`WIDTH*HEIGHT-1`.
- Interior centre: `1 <= r <= HEIGHT-2` and `1 <= c <= WIDTH-2`.
- `feed` rules:
  - Interior centre: `feed` = mean, computed combinationally from the current taps.
  - Any other cycle, including IDLE: `feed` = `R5`. The buffer then shifts unmodified.
- Mean: sum = R1+…+R9 (12-bit, max 2295); mean = floor((sum+4)/9). This is exact for all sums and the result is at most 255.
- Border centre output: raw `R5`. See Configuration.
- Output pipeline: stage 1 registers the pixel value with its eol/eof flags; stage 2 pushes into the FIFO.
  - `out_eol` is set when c = `WIDTH-1`.
  - `out_eof` is set on the final index.
- FIFO handling: push when full drops the pixel and sets `err`. A simultaneous push and pop when full is legal and is not an overflow.
- Reset values: `out_valid`=0, `out_pixel`=0, `out_eol`=0, `out_eof`=0, `busy`=0, `err`=0, state=IDLE, FIFO empty.
- Reset asserted mid-frame takes effect immediately and discards all state.

## Timing
- `feed` has 0-cycle latency from the taps.
- The pixel for centre index k enters the FIFO 2 cycles after that centre is present on `R5`. It appears on `out_pixel` in the same cycle it is pushed into an empty FIFO (FIFO is show-ahead).
- First output: `WIDTH+4` cycles after the first `in_valid`.
- Last output: `WIDTH*HEIGHT+WIDTH+3` cycles after the first `in_valid`. `busy` falls in the same cycle.
- The buffer cannot stall. `out_ready` low for more than `FIFO_DEPTH` consecutive output cycles causes overflow.
- `out_pixel`, `out_eol` and `out_eof` hold stable while `out_valid`=1 and `out_ready`=0.

## Configuration
- `MEAN_BORDER_ZERO_EN` defined: border centres output 0; `feed` stays equal to `R5`.
- `MEAN_BORDER_ZERO_EN` undefined: border centres output raw `R5`.

## Test plan
- WIDTH=8, HEIGHT=4, all pixels 100, `out_ready`=1: expect 32 outputs, all 100. `out_eol` on outputs 8, 16, 24 and 32; `out_eof` on output 32 only; `err`=0.
- Single interior window with taps 0,0,0,0,255,0,0,0,0 (sum 255): expect `feed` = 28 in the same cycle, then `out_pixel` = 28 two cycles later.
- Taps all 255: expect mean 255 (no overflow). Sum 13: expect mean 1. Sum 14: expect mean 2.
- Hold `out_ready`=0 for the whole frame with FIFO_DEPTH=4: expect 4 retained pixels, `err`=1, `busy` returns to 0. The next frame start clears `err`.
- Drop `in_valid` at pixel 10: expect `err`=1 and state IDLE. A new `in_valid` restarts the frame with correct first-output timing.
- Assert `rst` low mid-FLUSH: expect all outputs 0 immediately and no further pushes until a new frame.
